// File: rtl/stack_mem_pkg.sv
// Shared constants for the stack RAM arbiter: FSM encoding, default
// RAM geometry and the port index assignment.
package stack_mem_pkg;

    // Default geometry of the calculator's 128x8 stack RAM.
    localparam int STACK_ADDR_W = 7;
    localparam int STACK_DATA_W = 8;

    // Read-latency counter width; RD_LAT never exceeds 3.
    localparam int CNT_W = 2;

    // Arbiter FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Port index assignment.
    localparam logic PORT_CTRL = 1'b0;  // stack-control sequencer
    localparam logic PORT_DISP = 1'b1;  // display / debug read-out

endpackage

// File: rtl/stack_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, and on a
// tie the port that was not served last wins.
module rr_pick2
    import stack_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    // Pick the winning port from the current requests and the last grant.
    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            sel = (last == PORT_CTRL) ? PORT_DISP : PORT_CTRL;
        end else if (req[1]) begin
            sel = PORT_DISP;
        end else begin
            sel = PORT_CTRL;
        end
    end

endmodule

// File: rtl/stack_mem_arbiter.sv
// Shares the single-port stack RAM between the control sequencer (port 0)
// and the display read-out engine (port 1). One RAM cycle per access,
// round-robin between ports, reads returned with a registered rvalid
// pulse RD_LAT+1 cycles after the grant.
module stack_mem_arbiter
    import stack_mem_pkg::*;
#(
    parameter int ADDR_W = STACK_ADDR_W,
    parameter int DATA_W = STACK_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_q,   state_d;
    logic              sel_q,     sel_d;
    logic              last_q,    last_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] rdata0_q,  rdata0_d;
    logic [DATA_W-1:0] rdata1_q,  rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic              pick_valid;
    logic              pick_sel;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // Live fields of the port being served; only meaningful in ISSUE.
    assign issue_we    = (sel_q == PORT_DISP) ? we1    : we0;
    assign issue_addr  = (sel_q == PORT_DISP) ? addr1  : addr0;
    assign issue_wdata = (sel_q == PORT_DISP) ? wdata1 : wdata0;

    // FSM next state, RAM pin drive and read-data capture.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can leave a latch behind.
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_cs    = 1'b1;
                mem_we    = issue_we;
                mem_addr  = issue_addr;
                mem_wdata = issue_wdata;
                gnt0      = (sel_q == PORT_CTRL);
                gnt1      = (sel_q == PORT_DISP);
                last_d    = sel_q;
                if (issue_we) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // mem_rdata is only valid in the last wait cycle.
                if (cnt_q == CNT_W'(1)) begin
                    if (sel_q == PORT_DISP) begin
                        rdata1_d  = mem_rdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_rdata;
                        rvalid0_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; a reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= PORT_CTRL;
            last_q    <= PORT_DISP;  // port 0 wins the first tie
            cnt_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge value of every other register.
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Bench for stack_mem_arbiter: instance A uses RD_LAT=1, instance B uses
// RD_LAT=2. Each has its own behavioural RAM; read results are tracked
// with per-port scoreboard queues.
module tb_stack_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, req0_b, req1_b;
    logic       we0, we1;
    logic [6:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;

    logic       gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_cs_a, mem_we_a;
    logic [7:0] rdata0_a, rdata1_a, mem_wdata_a, mem_rdata_a;
    logic [6:0] mem_addr_a;
    logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_cs_b, mem_we_b;
    logic [7:0] rdata0_b, rdata1_b, mem_wdata_b, mem_rdata_b;
    logic [6:0] mem_addr_b;

    int         total = 0;
    int         bad   = 0;

    logic [7:0] exp_rd0_a[$];
    logic [7:0] exp_rd1_a[$];
    logic [7:0] exp_rd0_b[$];
    logic       grant_seq[$];

    always #5 clk = ~clk;

    stack_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a),
        .mem_cs(mem_cs_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    stack_mem_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .req1(req1_b), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b),
        .mem_cs(mem_cs_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // RAM model A: data valid for one cycle, one cycle after the issue edge.
    logic [7:0] mem_a [0:127];
    logic [7:0] rd_a;
    logic       v_a = 1'b0;
    always @(posedge clk) begin
        if (mem_cs_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
        rd_a <= mem_a[mem_addr_a];
        v_a  <= mem_cs_a && !mem_we_a;
    end
    assign mem_rdata_a = v_a ? rd_a : 8'hEE;

    // RAM model B: two-cycle latency; the garbage value EE is driven
    // whenever no read data is due.
    logic [7:0] mem_b [0:127];
    logic [7:0] rd_b1, rd_b2;
    logic       v_b1 = 1'b0, v_b2 = 1'b0;
    always @(posedge clk) begin
        if (mem_cs_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
        rd_b1 <= mem_b[mem_addr_b];
        v_b1  <= mem_cs_b && !mem_we_b;
        rd_b2 <= rd_b1;
        v_b2  <= v_b1;
    end
    assign mem_rdata_b = v_b2 ? rd_b2 : 8'hEE;

    function automatic void check(input string tag, input logic [63:0] obs,
                                  input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Scoreboard monitor: grants exclusive, each rvalid matches its own port.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0_a || gnt1_a) check("gnt_excl_a", gnt0_a & gnt1_a, 0);
            if (rvalid0_a) begin
                if (exp_rd0_a.size() == 0) check("rv0_a_unexpected", rvalid0_a, 0);
                else check("sb_rd0_a", rdata0_a, exp_rd0_a.pop_front());
            end
            if (rvalid1_a) begin
                if (exp_rd1_a.size() == 0) check("rv1_a_unexpected", rvalid1_a, 0);
                else check("sb_rd1_a", rdata1_a, exp_rd1_a.pop_front());
            end
            if (rvalid0_b) begin
                if (exp_rd0_b.size() == 0) check("rv0_b_unexpected", rvalid0_b, 0);
                else check("sb_rd0_b", rdata0_b, exp_rd0_b.pop_front());
            end
            if (rvalid1_b) check("rv1_b_unexpected", rvalid1_b, 0);
        end
    end

    // Single write on instance A with exact-cycle checks (T = request cycle).
    task automatic do_write_a(input logic port, input logic [6:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        if (port) begin req1 = 1; we1 = 1; addr1 = a; wdata1 = d; end
        else      begin req0 = 1; we0 = 1; addr0 = a; wdata0 = d; end
        @(negedge clk);
        check("wr_no_early_gnt", {gnt0_a, gnt1_a}, 0);
        @(negedge clk);
        check("wr_issue", {gnt0_a, gnt1_a, mem_cs_a, mem_we_a, mem_addr_a, mem_wdata_a},
              {~port, port, 1'b1, 1'b1, a, d});
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        check("wr_idle_pins", {gnt0_a, gnt1_a, mem_cs_a, mem_we_a, mem_addr_a, mem_wdata_a}, 0);
    endtask

    // Single read on instance A: gnt at T+1, rvalid/rdata at T+3.
    task automatic do_read_a(input logic port, input logic [6:0] a, input logic [7:0] d);
        if (port) exp_rd1_a.push_back(d); else exp_rd0_a.push_back(d);
        @(posedge clk); #1;
        if (port) begin req1 = 1; we1 = 0; addr1 = a; end
        else      begin req0 = 1; we0 = 0; addr0 = a; end
        @(negedge clk);
        @(negedge clk);
        check("rd_issue", {gnt0_a, gnt1_a, mem_cs_a, mem_we_a, mem_addr_a},
              {~port, port, 1'b1, 1'b0, a});
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        check("rd_wait", {mem_cs_a, mem_we_a, rvalid0_a, rvalid1_a}, 0);
        @(negedge clk);
        check("rd_rvalid", {rvalid0_a, rvalid1_a}, {~port, port});
        check("rd_data", port ? rdata1_a : rdata0_a, d);
        @(negedge clk);
        check("rd_hold", {rvalid0_a, rvalid1_a, (port ? rdata1_a : rdata0_a)}, {2'b00, d});
    endtask

    // Drop each held request once its grant is seen; record grant order.
    task automatic serve(input int budget);
        logic d0, d1;
        int   n = 0;
        while ((req0 || req1) && n < budget) begin
            @(negedge clk);
            d0 = gnt0_a;
            d1 = gnt1_a;
            if (d0) grant_seq.push_back(1'b0);
            if (d1) grant_seq.push_back(1'b1);
            @(posedge clk); #1;
            if (d0) req0 = 0;
            if (d1) req1 = 0;
            n++;
        end
        check("serve_budget", {req0, req1}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req0 = 0; req1 = 0; req0_b = 0; req1_b = 0;
        we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        #1;
        check("reset_outs_a", {gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_cs_a, mem_we_a,
                               mem_addr_a, mem_wdata_a, rdata0_a, rdata1_a}, 0);
        check("reset_outs_b", {gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_cs_b, mem_we_b,
                               mem_addr_b, mem_wdata_b, rdata0_b, rdata1_b}, 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Writes at both address extremes, then read-backs on each port.
        do_write_a(1'b0, 7'h7F, 8'hA5);
        do_write_a(1'b1, 7'h00, 8'h11);
        do_read_a(1'b1, 7'h7F, 8'hA5);
        do_read_a(1'b0, 7'h00, 8'h11);

        // Asynchronous reset mid-cycle with both ports requesting.
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 7'h7F; addr1 = 7'h00;
        #2 rst = 1;
        #1;
        check("rst_async_outs", {gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_cs_a, mem_we_a,
                                 mem_addr_a, mem_wdata_a, rdata0_a, rdata1_a}, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", {gnt0_a, gnt1_a, mem_cs_a, rvalid0_a, rvalid1_a}, 0);
        end

        // Simultaneous reads right after reset: port 0 first, then port 1.
        exp_rd0_a.push_back(8'hA5);
        exp_rd1_a.push_back(8'h11);
        grant_seq.delete();
        rst = 0;
        serve(20);
        repeat (4) @(negedge clk);
        check("tie_grant_count", grant_seq.size(), 2);
        if (grant_seq.size() == 2) check("tie_grant_order", {grant_seq[0], grant_seq[1]}, 2'b01);
        check("tie_rdata_ports", {rdata0_a, rdata1_a}, {8'hA5, 8'h11});

        // Sustained contention: 8 back-to-back writes must alternate.
        grant_seq.delete();
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 7'h10; addr1 = 7'h20; wdata0 = 8'hC0; wdata1 = 8'hC1;
        for (int c = 0; c < 40 && grant_seq.size() < 8; c++) begin
            @(negedge clk);
            if (gnt0_a) grant_seq.push_back(1'b0);
            if (gnt1_a) grant_seq.push_back(1'b1);
        end
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        check("contention_count", grant_seq.size(), 8);
        for (int i = 0; i < grant_seq.size(); i++) begin
            check($sformatf("contention_grant%0d", i), grant_seq[i], i % 2);
        end

        // Reset during a port 1 WAIT: the read is abandoned.
        @(posedge clk); #1;
        req1 = 1; we1 = 0; addr1 = 7'h7F;
        @(negedge clk);
        @(negedge clk);
        check("abort_gnt1", {gnt0_a, gnt1_a}, 2'b01);
        @(posedge clk); #1;
        req1 = 0;
        #2 rst = 1;
        #1 check("abort_rst_outs", {rvalid1_a, mem_cs_a, gnt0_a, gnt1_a}, 0);
        #2 rst = 0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rvalid1", {rvalid0_a, rvalid1_a}, 0);
        end
        // Following tie: port 0 at T+1, port 1 at T+3.
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 7'h30; addr1 = 7'h31; wdata0 = 8'h30; wdata1 = 8'h31;
        @(negedge clk);
        @(negedge clk);
        check("post_abort_tie0", {gnt0_a, gnt1_a}, 2'b10);
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        check("post_abort_gap", {gnt0_a, gnt1_a}, 2'b00);
        @(negedge clk);
        check("post_abort_tie1", {gnt0_a, gnt1_a, mem_addr_a, mem_wdata_a},
              {2'b01, 7'h31, 8'h31});
        @(posedge clk); #1;
        req1 = 0;

        // RD_LAT=2 instance: write 3C then read it back, rvalid0 at T+4.
        @(posedge clk); #1;
        req0_b = 1; we0 = 1; addr0 = 7'h05; wdata0 = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        check("b_wr_issue", {gnt0_b, gnt1_b, mem_cs_b, mem_we_b, mem_addr_b, mem_wdata_b},
              {2'b10, 2'b11, 7'h05, 8'h3C});
        @(posedge clk); #1;
        req0_b = 0;
        exp_rd0_b.push_back(8'h3C);
        @(posedge clk); #1;
        req0_b = 1; we0 = 0; addr0 = 7'h05;
        @(negedge clk);
        @(negedge clk);
        check("b_rd_issue", {gnt0_b, mem_cs_b, mem_we_b, mem_addr_b}, {3'b110, 7'h05});
        @(posedge clk); #1;
        req0_b = 0;
        @(negedge clk);
        check("b_wait1", {rvalid0_b, mem_cs_b, mem_we_b}, 0);
        @(negedge clk);
        check("b_wait2", {rvalid0_b, mem_cs_b}, 0);
        @(negedge clk);
        check("b_rvalid", {rvalid0_b, rdata0_b}, {1'b1, 8'h3C});
        @(negedge clk);
        check("b_rvalid_pulse", {rvalid0_b, rdata0_b}, {1'b0, 8'h3C});

        repeat (2) @(negedge clk);
        check("sb_empty", {exp_rd0_a.size(), exp_rd1_a.size()}, 0);
        check("sb_empty_b", exp_rd0_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_mem_arbiter.md
# stack_mem_arbiter

Two-port arbiter that shares the calculator's single-port 128x8 stack RAM between the stack-control sequencer (port 0) and a second requester such as the display/debug read-out engine (port 1). Each port uses a req/gnt handshake. Every access is a single RAM cycle, and ports are served round-robin. Reads are returned to the requesting port with an `rvalid` pulse after the RAM's fixed read latency. The block sits between the requesters and the RAM's `cs`/`we`/`address`/`data` pins, and it is the only driver of those pins.

## Interface
- `ADDR_W`, 7, RAM address width
- `DATA_W`, 8, RAM data width
- `RD_LAT`, 1, RAM read latency in cycles: cycles from the issue edge until `mem_rdata` is valid; legal values 1..3
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req0`, `req1`  in  1  access request; hold high, with fields stable, until the matching `gnt` is seen
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  access address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  one-cycle pulse; high during the cycle the port's access is driven onto the RAM
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdata` for that port is valid
- `rdata0`, `rdata1`  out  DATA_W  read data; holds until the port's next read completes
- `mem_cs`, `mem_we`  out  1  RAM chip select and write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data

## Operation
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - With any `req` high, register the selected port into `sel` and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - `mem_cs`=1, and `gnt[sel]`=1.
  - `mem_we`, `mem_addr` and `mem_wdata` come from the selected port's live inputs.
  - `last` <= `sel`.
  - For a write, go to IDLE.
  - For a read, load the wait counter with `RD_LAT` and go to WAIT.
- **WAIT:**
  - `mem_cs`=0 and `mem_we`=0.
  - Decrement the counter each cycle.
  - In the cycle the counter reads 1, capture `mem_rdata` into `rdata[sel]`, set `rvalid[sel]` for the next cycle, and go to IDLE.
- **Arbitration:**
  - If only one port requests, that port is chosen.
  - If both request, the port != `last` is chosen.
  - `last` resets to 1, so port 0 wins the first tie after reset.
- **Outputs outside ISSUE:** `mem_addr`/`mem_wdata` are driven to 0. `gnt0` and `gnt1` are never high together.
- **Reset values:**
  - All outputs are 0, including `rdata0`/`rdata1`.
  - State = IDLE, `last` = 1, counter = 0.
- **Reset mid-operation:** an access in ISSUE or WAIT is abandoned. No `rvalid` is produced, and the port must re-request.
- **Protocol rules:**
  - `req` held high after `gnt` is treated as a new request.
  - A `req` dropped before `gnt` while the arbiter is in IDLE causes no access.
  - A `req` dropped during ISSUE is illegal. The access still completes using the live fields.
- **Addressing:** addresses pass through unmodified. There is no wrap or range logic; 7'h00 and 7'h7F are ordinary addresses.

## Timing
- **Write:**
  - `req` seen in IDLE at cycle T.
  - ISSUE and `gnt` at T+1.
  - IDLE at T+2.
  - Minimum spacing between writes is 2 cycles.
- **Read:**
  - `req` seen in IDLE at cycle T.
  - ISSUE and `gnt` at T+1.
  - WAIT from T+2 to T+1+`RD_LAT`.
  - `rdata`/`rvalid` valid at T+2+`RD_LAT`. That cycle is IDLE, and a new arbitration may occur in it.
- `rvalid` is registered, so its latency has no combinational path from `mem_rdata`.
- **Back-to-back traffic:** with both ports continuously requesting, grants alternate 0,1,0,1.

## Structure
- **Package `stack_mem_pkg`:**
  - State encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2.
  - Default widths `ADDR_W`=7 and `DATA_W`=8.
  - Port index constants `PORT_CTRL`=0 and `PORT_DISP`=1.
- **Sub-module `rr_pick2`:** combinational 2-way round-robin picker. Inputs `req[1:0]` and `last`; outputs `valid` and `sel`. Instantiated once.
- All state, `sel`, `last`, counter, `rdata` and `rvalid` registers live in the top module.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle. All outputs go to 0 immediately and stay 0 while `rst` is high, with no `gnt` despite `req0`=`req1`=1.
- **Write then read back (`RD_LAT`=1):**
  - Port 0 writes 8'hA5 to 7'h7F. `gnt0`, `mem_cs`=1, `mem_we`=1, `mem_addr`=7'h7F and `mem_wdata`=8'hA5 all occur in one cycle.
  - Port 1 then reads 7'h7F. `gnt1` occurs at T+1, and `rvalid1`=1 with `rdata1`=8'hA5 at T+3.
- **Simultaneous read requests after reset:** port 0 is granted first, then port 1. `gnt0` and `gnt1` are never high together, and each `rvalid` goes only to its own port.
- **Sustained contention:** both `req` lines held high for 8 accesses. The grant sequence is 0,1,0,1,0,1,0,1, and no port waits more than one other access.
- **Reset during WAIT:** `rst` pulsed during a port 1 read. No `rvalid1`, state returns to IDLE, and a following tie grants port 0.
- **`RD_LAT`=2:** a port 0 read of an address holding 8'h3C gives `rvalid0` at T+4 with `rdata0`=8'h3C. `mem_rdata` is ignored in the first WAIT cycle.
